reg_file_sb: RTL and testbench

//  Parametrised 2-read/1-write register file with a per-register pending-write scoreboard,

---
 rtl/reg_file_sb_pkg.sv | 10 +
 rtl/reg_file_sb_scoreboard.sv | 47 ++++
 rtl/reg_file_sb.sv | 106 ++++++++++
 tb/tb_reg_file_sb.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and clear-engine state encoding for the scoreboarded register file.
package reg_file_sb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservation, cleared by
// write-back or the bulk-clear sweep, with bypass-aware busy lookups for two ports.
module reg_file_sb_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_fire_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              rsv_fire_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              bulk_fire_i,
    input  logic [ADDR_W-1:0] bulk_addr_i,
    input  logic              force_busy_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic              busy_a_o,
    output logic              busy_b_o
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam bit BYP      = (BYPASS != 0);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic                hit_a;
    logic                hit_b;

    // Reservation is applied last: it belongs to a newer producer than the write-back.
    always_comb begin
        pend_d = pend_q;
        if (bulk_fire_i) pend_d[bulk_addr_i] = 1'b0;
        if (wr_fire_i)   pend_d[wr_addr_i]   = 1'b0;
        if (rsv_fire_i)  pend_d[rsv_addr_i]  = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    assign hit_a    = BYP && wr_fire_i && (wr_addr_i == rd_addr_a_i);
    assign hit_b    = BYP && wr_fire_i && (wr_addr_i == rd_addr_b_i);
    assign busy_a_o = force_busy_i | ((rd_addr_a_i != '0) & pend_q[rd_addr_a_i] & ~hit_a);
    assign busy_b_o = force_busy_i | ((rd_addr_b_i != '0) & pend_q[rd_addr_b_i] & ~hit_b);
endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with pending-write scoreboard, write-through bypass
// and a one-register-per-cycle bulk-clear engine. Register 0 reads as zero.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                BYPASS    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam bit BYP      = (BYPASS != 0);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic idle;
    logic clearing;
    logic wr_fire;
    logic rsv_fire;
    logic byp_a;
    logic byp_b;

    assign idle     = (state_q == ST_IDLE);
    assign clearing = (state_q == ST_CLEAR);
    assign wr_fire  = idle && wr_en  && (wr_addr  != '0);
    assign rsv_fire = idle && rsv_en && (rsv_addr != '0);
    assign clr_busy = clearing;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= ADDR_W'(1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= ADDR_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= ADDR_W'(1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= (i == 0) ? '0 : RESET_VAL;
        end else if (clearing) begin
            rf_q[cnt_q] <= RESET_VAL;
        end else if (wr_fire) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    // During a clear the bypass is off and storage is returned raw; busy covers it.
    assign byp_a     = BYP && wr_fire && (wr_addr == rd_addr_a);
    assign byp_b     = BYP && wr_fire && (wr_addr == rd_addr_b);
    assign rd_data_a = (rd_addr_a == '0) ? '0 : (byp_a ? wr_data : rf_q[rd_addr_a]);
    assign rd_data_b = (rd_addr_b == '0) ? '0 : (byp_b ? wr_data : rf_q[rd_addr_b]);

    reg_file_sb_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_sb (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_fire_i    (wr_fire),
        .wr_addr_i    (wr_addr),
        .rsv_fire_i   (rsv_fire),
        .rsv_addr_i   (rsv_addr),
        .bulk_fire_i  (clearing),
        .bulk_addr_i  (cnt_q),
        .force_busy_i (clearing),
        .rd_addr_a_i  (rd_addr_a),
        .rd_addr_b_i  (rd_addr_b),
        .busy_a_o     (busy_a),
        .busy_b_o     (busy_b)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing instance and a non-bypassing instance share stimulus
// and are compared against an array/queue-level reference model.
module tb_reg_file_sb;
    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV1 = 32'hC0DE_0001;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic        wr_en, rsv_en, clr_req;
    logic [31:0] wr_data;
    logic [31:0] rda [2];
    logic [31:0] rdb [2];
    logic        ba [2];
    logic        bb [2];
    logic        cb [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [2][32];
    bit          m_pend [32];
    int          m_clr_left;
    int          m_clr_pos;

    always #5 clock = ~clock;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .RESET_VAL(RV0), .BYPASS(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .busy_a(ba[0]), .busy_b(bb[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(cb[0])
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .RESET_VAL(RV1), .BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .busy_a(ba[1]), .busy_b(bb[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(cb[1])
    );

    function automatic logic [31:0] rv(int d);
        return (d == 0) ? RV0 : RV1;
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) m_rf[d][r] = (r == 0) ? 32'h0 : rv(d);
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        m_clr_left = 0;
        m_clr_pos  = 1;
    endfunction

    // One clock edge of the architectural behaviour, using the inputs held across it.
    function automatic void m_step();
        if (m_clr_left > 0) begin
            for (int d = 0; d < 2; d++) m_rf[d][m_clr_pos] = rv(d);
            m_pend[m_clr_pos] = 1'b0;
            m_clr_pos++;
            m_clr_left--;
        end else begin
            if (wr_en && wr_addr != 0) begin
                for (int d = 0; d < 2; d++) m_rf[d][wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
            if (clr_req) begin
                m_clr_left = 31;
                m_clr_pos  = 1;
            end
        end
    endfunction

    function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
        if (a == 0) return 32'h0;
        if (d == 0 && m_clr_left == 0 && wr_en && wr_addr == a) return wr_data;
        return m_rf[d][a];
    endfunction

    function automatic logic exp_busy(int d, logic [4:0] a);
        if (m_clr_left > 0) return 1'b1;
        if (a == 0) return 1'b0;
        return m_pend[a] && !(d == 0 && wr_en && wr_addr == a);
    endfunction

    task automatic idle_inputs();
        wr_en = 0; rsv_en = 0; clr_req = 0;
        wr_addr = 0; rsv_addr = 0; wr_data = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) m_step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int r = 1; r < 6; r++) begin
            wr_en = 1; wr_addr = 5'(r); wr_data = $urandom;
            rsv_en = 1; rsv_addr = 5'(r + 10);
            tick();
        end
        idle_inputs();
        #2 reset_n = 0;
        m_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cb[d] !== 1'b0) begin
                errors++; $display("FAIL reset_clr_busy dut%0d: got %b exp 0", d, cb[d]);
            end
        end
        for (int r = 0; r < 32; r++) begin
            rd_addr_a = 5'(r); rd_addr_b = 5'(31 - r);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rda[d] !== ((r == 0) ? 32'h0 : rv(d)) || ba[d] !== 1'b0 || bb[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read dut%0d r%0d: got data %h busy %b%b exp data %h busy 00",
                             d, r, rda[d], ba[d], bb[d], (r == 0) ? 32'h0 : rv(d));
                end
            end
        end
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; rd_addr_a = 0;
        tick();
        idle_inputs(); rd_addr_a = 5;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rda[d] !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL wr_rd_r5 dut%0d: got %h exp deadbeef", d, rda[d]);
            end
        end
        @(negedge clock);
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        tick();
        idle_inputs(); rd_addr_a = 0; rd_addr_b = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rda[d] !== 32'h0 || rdb[d] !== 32'h0) begin
                errors++; $display("FAIL wr_rd_r0 dut%0d: got %h/%h exp 0", d, rda[d], rdb[d]);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_bypass();
        logic [31:0] old_nb;
        rsv_en = 1; rsv_addr = 7;
        tick();
        idle_inputs();
        old_nb = m_rf[1][7];
        rd_addr_b = 7; wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (rdb[0] !== 32'hA5A5_A5A5 || bb[0] !== 1'b0) begin
            errors++; $display("FAIL bypass_on: got %h busy %b exp a5a5a5a5 busy 0", rdb[0], bb[0]);
        end
        checks++;
        if (rdb[1] !== old_nb || bb[1] !== 1'b1) begin
            errors++; $display("FAIL bypass_off: got %h busy %b exp %h busy 1", rdb[1], bb[1], old_nb);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rdb[1] !== 32'hA5A5_A5A5 || bb[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_off_after: got %h busy %b exp a5a5a5a5 busy 0", rdb[1], bb[1]);
        end
        @(negedge clock);
    endtask

    task automatic test_scoreboard();
        logic [31:0] y;
        rd_addr_a = 9; rsv_en = 1; rsv_addr = 9;
        #1;
        checks++;
        if (ba[0] !== 1'b0) begin
            errors++; $display("FAIL sb_c0: got %b exp 0", ba[0]);
        end
        tick(); idle_inputs();
        for (int c = 1; c <= 2; c++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (ba[d] !== 1'b1) begin
                    errors++; $display("FAIL sb_c%0d dut%0d: got %b exp 1", c, d, ba[d]);
                end
            end
            tick();
        end
        wr_en = 1; wr_addr = 9; wr_data = 32'h0BAD_F00D;
        #1;
        checks++;
        if (ba[0] !== 1'b0 || ba[1] !== 1'b1) begin
            errors++; $display("FAIL sb_c3: got %b%b exp 01", ba[0], ba[1]);
        end
        tick(); idle_inputs();
        #1;
        checks++;
        if (ba[0] !== 1'b0 || ba[1] !== 1'b0) begin
            errors++; $display("FAIL sb_c4: got %b%b exp 00", ba[0], ba[1]);
        end
        @(negedge clock);
        y = $urandom;
        wr_en = 1; wr_addr = 9; wr_data = y; rsv_en = 1; rsv_addr = 9;
        tick(); idle_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ba[d] !== 1'b1 || rda[d] !== y) begin
                errors++; $display("FAIL sb_rsv_wr dut%0d: got %h busy %b exp %h busy 1", d, rda[d], ba[d], y);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rd_addr_a = 5'($urandom_range(0, 7));
            rd_addr_b = 5'($urandom_range(0, 7));
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            rsv_en    = ($urandom_range(0, 2) == 0);
            rsv_addr  = 5'($urandom_range(0, 7));
            clr_req   = ($urandom_range(0, 99) == 0);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rda[d] !== exp_rd(d, rd_addr_a) || rdb[d] !== exp_rd(d, rd_addr_b)) begin
                    errors++;
                    $display("FAIL rand_rd dut%0d it%0d: got %h/%h exp %h/%h", d, n,
                             rda[d], rdb[d], exp_rd(d, rd_addr_a), exp_rd(d, rd_addr_b));
                end
                checks++;
                if (ba[d] !== exp_busy(d, rd_addr_a) || bb[d] !== exp_busy(d, rd_addr_b)
                    || cb[d] !== (m_clr_left > 0)) begin
                    errors++;
                    $display("FAIL rand_busy dut%0d it%0d: got %b%b%b exp %b%b%b", d, n, ba[d], bb[d],
                             cb[d], exp_busy(d, rd_addr_a), exp_busy(d, rd_addr_b), m_clr_left > 0);
                end
            end
            tick();
        end
        idle_inputs();
        while (m_clr_left > 0) tick();
    endtask

    task automatic sweep_after_clear(string tag);
        for (int r = 0; r < 32; r++) begin
            rd_addr_a = 5'(r); rd_addr_b = 5'(r);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rda[d] !== ((r == 0) ? 32'h0 : rv(d)) || ba[d] !== 1'b0 || bb[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s dut%0d r%0d: got %h busy %b%b exp %h busy 00", tag, d, r,
                             rda[d], ba[d], bb[d], (r == 0) ? 32'h0 : rv(d));
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic run_clear_count(string tag, int drop_wr_at);
        int cyc = 0;
        clr_req = 1;
        tick();
        clr_req = 0;
        while (cb[0] === 1'b1 && cyc < 100) begin
            if (cyc == drop_wr_at) begin
                wr_en = 1; wr_addr = 3; wr_data = 32'h55; rsv_en = 1; rsv_addr = 3; rd_addr_a = 0;
                #1;
                checks++;
                if (ba[0] !== 1'b1 || ba[1] !== 1'b1 || cb[1] !== 1'b1) begin
                    errors++; $display("FAIL %s_forced_busy: got %b%b%b exp 111", tag, ba[0], ba[1], cb[1]);
                end
            end
            tick();
            idle_inputs();
            cyc++;
        end
        checks++;
        if (cyc != 31) begin
            errors++; $display("FAIL %s_len: got %0d cycles exp 31", tag, cyc);
        end
    endtask

    task automatic test_clear();
        for (int r = 1; r < 32; r++) begin
            wr_en = 1; wr_addr = 5'(r); wr_data = 32'hFFFF_FFFF;
            rsv_en = (r % 3 == 0); rsv_addr = 5'(r);
            tick();
        end
        idle_inputs();
        run_clear_count("clear", 5);
        sweep_after_clear("clear_after");
    endtask

    task automatic test_reset_mid_clear();
        for (int r = 1; r < 32; r += 2) begin
            wr_en = 1; wr_addr = 5'(r); wr_data = $urandom; rsv_en = 1; rsv_addr = 5'(r + 1);
            tick();
        end
        idle_inputs();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (10) tick();
        #2 reset_n = 0;
        m_reset();
        #1;
        checks++;
        if (cb[0] !== 1'b0 || cb[1] !== 1'b0) begin
            errors++; $display("FAIL midclr_busy: got %b%b exp 00", cb[0], cb[1]);
        end
        sweep_after_clear("midclr_regs");
        reset_n = 1;
        @(negedge clock);
        run_clear_count("midclr_rerun", -1);
        sweep_after_clear("midclr_rerun_after");
    endtask

    initial begin
        idle_inputs();
        rd_addr_a = 0; rd_addr_b = 0;
        reset_n = 0;
        m_reset();
        repeat (2) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
